life_manager: RTL
=================

# life_manager

Parametrised lives tracker for the ping-pong game that generalises the single-player miss counter to N players. It counts saturating lives per player, adds bonus lives, and ignores repeat misses during a post-miss hold-off window. It also runs a game state machine (idle / play / hold-off / over) that drives serve and game-over signalling to the ball and display logic. It sits between the collision/miss detectors and the score display.

## Interface
Parameters:
- NUM_PLAYERS, 2, number of players; legal range ≥1.
- LIFE_W, 3, width of each lives field.
- START_LIVES, 3, lives loaded at game start; legal range 1..MAX_LIVES.
- MAX_LIVES, 7, bonus saturation ceiling; must be < 2^LIFE_W.
- MISS_HOLDOFF, 1000, length of the HOLDOFF state in cycles; legal range ≥1.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous, active-high.
- start, input, 1, single-cycle pulse; begins a game from IDLE or OVER.
- miss, input, NUM_PLAYERS, level per player; a rising edge is one miss.
- bonus, input, NUM_PLAYERS, level per player; a rising edge is one bonus life.
- lives, output, NUM_PLAYERS*LIFE_W, packed per-player counts; player i occupies [i*LIFE_W +: LIFE_W].
- state, output, 2, encoding IDLE=0, PLAY=1, HOLDOFF=2, OVER=3.
- serve, output, 1, one-cycle pulse on each entry to PLAY.
- game_over, output, 1, high while in OVER.
- winner, output, NUM_PLAYERS, bit set for each player with nonzero lives in OVER; 0 outside OVER.

## Operation
- Reset values:
  - state=IDLE.
  - Every lives field = START_LIVES.
  - serve=0, game_over=0, winner=0.
  - Hold-off counter = 0.
  - Edge registers miss_prev=0 and bonus_prev=0.
- Edge detection: miss_prev and bonus_prev update every cycle in every state. A level held across states never re-triggers.
- IDLE: lives held at START_LIVES; miss and bonus edges are ignored. On start: go to PLAY and pulse serve.
- PLAY: for each player i with a miss edge, decrement lives[i], saturating at 0.
  - If any lives field reaches 0 as a result: go to OVER.
  - Else if any miss edge occurred: go to HOLDOFF and load the counter with MISS_HOLDOFF-1.
- HOLDOFF:
  - Miss edges are ignored.
  - The counter decrements each cycle.
  - At counter 0: go to PLAY and pulse serve.
  - HOLDOFF therefore lasts exactly MISS_HOLDOFF cycles.
- Bonus edges are accepted in PLAY and HOLDOFF only. Each increments lives[i], saturating at MAX_LIVES.
- Same-player miss and bonus edge in the same PLAY cycle: net zero, lives unchanged. The miss still counts as an event, so the state goes to HOLDOFF.
- Several players missing in the same cycle: all decrement. If more than one reaches 0, winner reflects only the survivors; all-zero gives winner=0, which is a draw.
- OVER: lives and winner are frozen. On start: reload all lives to START_LIVES, go to PLAY, pulse serve.
- start is ignored in PLAY and HOLDOFF.
- Reset mid-game: returns to IDLE on the next edge regardless of state or counter value.
- Arithmetic is LIFE_W-bit unsigned. The saturation compares are against 0 and MAX_LIVES; no wrap-around is permitted.

## Timing
- All outputs are registered.
- A miss/bonus level rising at sampled edge n appears in lives at edge n+1 (latency 1).
- The state transition on a miss occurs on the same edge as the lives update.
- game_over and winner are valid on the same edge that lives reaches 0.
- serve is high for the single cycle after the PLAY-entry edge.
- From the miss edge to serve: 1 + MISS_HOLDOFF cycles.
- start-to-serve latency is 1 cycle.

## Test plan
Parameters: NUM_PLAYERS=2, LIFE_W=3, START_LIVES=3, MAX_LIVES=4, MISS_HOLDOFF=4.
- **Reset and start:** reset, then start pulse → lives={3,3}, state=PLAY, serve high 1 cycle.
- **Hold-off masking:**
  - Raise miss[0] → lives[0]=2 next cycle, state=HOLDOFF.
  - A new miss[0] edge within the 4 cycles is ignored.
  - serve pulses 5 cycles after the miss.
  - A miss[0] held high the whole time does not re-decrement.
- **Bonus and simultaneous events:**
  - Two bonus[1] edges → lives[1]=4, saturated at MAX_LIVES.
  - miss[1] and bonus[1] edges in the same cycle → lives[1] unchanged, state=HOLDOFF.
- **Game over:**
  - Three spaced miss[0] edges → lives[0]=0, state=OVER, game_over=1, winner=2'b10.
  - A further miss is ignored.
  - start → lives={3,3}, PLAY, serve.
- **Draw:** both lives=1 and miss=2'b11 in one cycle → lives={0,0}, OVER, winner=0.
- **Mid-operation reset:** reset asserted in HOLDOFF with counter=2 → next cycle state=IDLE, lives={3,3}, serve=0, game_over=0.

Source files
------------

// File: rtl/life_manager.sv
`default_nettype none
// ============================================================================
// life_manager : N-player saturating lives tracker with miss hold-off and
//                idle/play/hold-off/over game state machine.
// Revision     : 1.0
// ============================================================================
module life_manager #(
    parameter int NUM_PLAYERS  = 2,
    parameter int LIFE_W       = 3,
    parameter int START_LIVES  = 3,
    parameter int MAX_LIVES    = 7,
    parameter int MISS_HOLDOFF = 1000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [NUM_PLAYERS-1:0]        miss,
    input  logic [NUM_PLAYERS-1:0]        bonus,
    output logic [NUM_PLAYERS*LIFE_W-1:0] lives,
    output logic [1:0]                    state,
    output logic                          serve,
    output logic                          game_over,
    output logic [NUM_PLAYERS-1:0]        winner
);

    localparam int                CNT_W     = (MISS_HOLDOFF > 1) ? $clog2(MISS_HOLDOFF) : 1;
    localparam logic [LIFE_W-1:0] START_L   = LIFE_W'(START_LIVES);
    localparam logic [LIFE_W-1:0] MAX_L     = LIFE_W'(MAX_LIVES);
    localparam logic [CNT_W-1:0]  HOLD_LOAD = CNT_W'(MISS_HOLDOFF - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PLAY    = 2'd1,
        S_HOLDOFF = 2'd2,
        S_OVER    = 2'd3
    } state_t;

    state_t                             state_q, state_d;
    logic [NUM_PLAYERS-1:0][LIFE_W-1:0] lives_q, lives_d, lives_adj;
    logic [CNT_W-1:0]                   cnt_q, cnt_d;
    logic                               serve_q, serve_d;
    logic                               game_over_q, game_over_d;
    logic [NUM_PLAYERS-1:0]             winner_q, winner_d;
    logic [NUM_PLAYERS-1:0]             miss_prev_q, bonus_prev_q;
    logic [NUM_PLAYERS-1:0]             miss_edge, bonus_edge;
    logic [NUM_PLAYERS-1:0]             miss_eff, bonus_eff, alive;

    // Per-player saturating arithmetic; a same-cycle miss and bonus cancel.
    always_comb begin
        miss_edge  = miss & ~miss_prev_q;
        bonus_edge = bonus & ~bonus_prev_q;
        miss_eff   = (state_q == S_PLAY) ? miss_edge : '0;
        bonus_eff  = ((state_q == S_PLAY) || (state_q == S_HOLDOFF)) ? bonus_edge : '0;
        lives_adj  = lives_q;
        alive      = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (miss_eff[i] && !bonus_eff[i]) begin
                if (lives_q[i] != '0) begin
                    lives_adj[i] = lives_q[i] - LIFE_W'(1);
                end
            end else if (bonus_eff[i] && !miss_eff[i]) begin
                if (lives_q[i] < MAX_L) begin
                    lives_adj[i] = lives_q[i] + LIFE_W'(1);
                end
            end
            alive[i] = (lives_adj[i] != '0);
        end
    end

    always_comb begin
        state_d  = state_q;
        lives_d  = lives_q;
        cnt_d    = cnt_q;
        serve_d  = 1'b0;
        winner_d = '0;
        case (state_q)
            S_IDLE: begin
                lives_d = {NUM_PLAYERS{START_L}};
                if (start) begin
                    state_d = S_PLAY;
                    serve_d = 1'b1;
                end
            end
            S_PLAY: begin
                lives_d = lives_adj;
                if (alive != '1) begin
                    state_d  = S_OVER;
                    winner_d = alive;
                end else if (|miss_eff) begin
                    state_d = S_HOLDOFF;
                    cnt_d   = HOLD_LOAD;
                end
            end
            S_HOLDOFF: begin
                lives_d = lives_adj;
                if (cnt_q == '0) begin
                    state_d = S_PLAY;
                    serve_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_OVER: begin
                winner_d = winner_q;
                if (start) begin
                    lives_d  = {NUM_PLAYERS{START_L}};
                    state_d  = S_PLAY;
                    serve_d  = 1'b1;
                    winner_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        game_over_d = (state_d == S_OVER);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            lives_q      <= {NUM_PLAYERS{START_L}};
            cnt_q        <= '0;
            serve_q      <= 1'b0;
            game_over_q  <= 1'b0;
            winner_q     <= '0;
            miss_prev_q  <= '0;
            bonus_prev_q <= '0;
        end else begin
            state_q      <= state_d;
            lives_q      <= lives_d;
            cnt_q        <= cnt_d;
            serve_q      <= serve_d;
            game_over_q  <= game_over_d;
            winner_q     <= winner_d;
            miss_prev_q  <= miss;
            bonus_prev_q <= bonus;
        end
    end

    assign lives     = lives_q;
    assign state     = state_q;
    assign serve     = serve_q;
    assign game_over = game_over_q;
    assign winner    = winner_q;

endmodule
`default_nettype wire
